// File: rtl/sonar_on_chip_pkg.sv
// Shared constants, register map and saturation helpers for the sonar front end.
// Widths cover the PDM input, CIC accumulator, decimated PCM sample and FIR output.
package sonar_on_chip_pkg;

    localparam int unsigned PdmWidth  = 1;
    localparam int unsigned CicWidth  = 20;
    localparam int unsigned PcmWidth  = 12;
    localparam int unsigned FirWidth  = 16;
    localparam int unsigned CoefWidth = 16;
    localparam int unsigned AccWidth  = 34;
    localparam int unsigned CicOrder  = 3;
    localparam int unsigned FirFrac   = 15;

    typedef enum logic [2:0] {
        RegCtrl   = 3'd0,
        RegB0     = 3'd1,
        RegB1     = 3'd2,
        RegB2     = 3'd3,
        RegThresh = 3'd4,
        RegFirOut = 3'd5,
        RegPeak   = 3'd6,
        RegCicOut = 3'd7
    } reg_addr_e;

    localparam logic                 CtrlEnableReset = 1'b1;
    localparam logic [CoefWidth-1:0] B0Reset         = 16'h7FFF;
    localparam logic [CoefWidth-1:0] B1Reset         = 16'h0000;
    localparam logic [CoefWidth-1:0] B2Reset         = 16'h0000;
    localparam logic [FirWidth-1:0]  ThreshReset     = 16'h0100;

    function automatic logic signed [PcmWidth-1:0] sat_pcm(input logic signed [CicWidth-1:0] v);
        if (v > 20'sd2047) begin
            return 12'sh7FF;
        end else if (v < -20'sd2048) begin
            return 12'sh800;
        end
        return v[PcmWidth-1:0];
    endfunction

    function automatic logic signed [FirWidth-1:0] sat_fir(input logic signed [AccWidth-1:0] v);
        if (v > 34'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -34'sd32768) begin
            return 16'sh8000;
        end
        return v[FirWidth-1:0];
    endfunction

endpackage

// File: rtl/sonar_on_chip_cic.sv
// Third-order CIC decimator: integrators at the PDM rate, combs at the PCM rate,
// followed by an arithmetic shift and 12-bit saturation.
module cic_decimator
    import sonar_on_chip_pkg::*;
#(
    parameter int unsigned CicShift = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       ce_pdm_i,
    input  logic                       ce_pcm_i,
    input  logic                       pdm_i,
    output logic signed [PcmWidth-1:0] pcm_o,
    output logic                       pcm_vld_o
);

    logic signed [CicWidth-1:0] integ_q    [CicOrder];
    logic signed [CicWidth-1:0] comb_dly_q [CicOrder];
    logic signed [CicWidth-1:0] comb_stage [CicOrder+1];
    logic signed [CicWidth-1:0] pdm_val;
    logic signed [CicWidth-1:0] shifted;
    logic signed [PcmWidth-1:0] pcm_q;
    logic                       pcm_vld_q;

    always_comb begin
        pdm_val       = pdm_i ? 20'sd1 : -20'sd1;
        // Comb chain reads registered integrator state, so a same-cycle ce_pdm
        // update is not seen until the next decimated sample.
        comb_stage[0] = integ_q[CicOrder-1];
        for (int i = 0; i < int'(CicOrder); i++) begin
            comb_stage[i+1] = comb_stage[i] - comb_dly_q[i];
        end
        shifted = comb_stage[CicOrder] >>> CicShift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CicOrder); i++) begin
                integ_q[i]    <= '0;
                comb_dly_q[i] <= '0;
            end
            pcm_q     <= '0;
            pcm_vld_q <= 1'b0;
        end else begin
            pcm_vld_q <= 1'b0;
            if (en_i && ce_pdm_i) begin
                integ_q[0] <= integ_q[0] + pdm_val;
                for (int i = 1; i < int'(CicOrder); i++) begin
                    integ_q[i] <= integ_q[i] + integ_q[i-1];
                end
            end
            if (en_i && ce_pcm_i) begin
                for (int i = 0; i < int'(CicOrder); i++) begin
                    comb_dly_q[i] <= comb_stage[i];
                end
                pcm_q     <= sat_pcm(shifted);
                pcm_vld_q <= 1'b1;
            end
        end
    end

    assign pcm_o     = pcm_q;
    assign pcm_vld_o = pcm_vld_q;

endmodule

// File: rtl/sonar_on_chip.sv
// Sonar front end: PDM -> CIC decimator -> 3-tap FIR -> peak hold and threshold
// detect, with a small register file on a single-cycle-ack bus.
module sonar_on_chip
    import sonar_on_chip_pkg::*;
#(
    parameter int unsigned CIC_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] adr_i,
    input  logic [15:0] dat_i,
    input  logic        strb_i,
    output logic        ack_o,
    output logic [15:0] dat_o,
    input  logic        ce_pdm,
    input  logic        ce_pcm,
    input  logic        pdm_data_i,
    input  logic        mclear,
    output logic        cmp
);

    logic                        enable_q;
    logic [CoefWidth-1:0]        b0_q, b1_q, b2_q;
    logic [FirWidth-1:0]         thresh_q;
    logic signed [PcmWidth-1:0]  cic_pcm;
    logic                        cic_vld;
    logic signed [PcmWidth-1:0]  x1_q, x2_q;
    logic signed [FirWidth-1:0]  fir_out_q;
    logic                        fir_vld_q;
    logic [FirWidth-1:0]         peak_q;
    logic                        cmp_q;
    logic                        ack_q;
    logic [15:0]                 dat_q;
    logic                        bus_req;
    reg_addr_e                   reg_addr;
    logic [15:0]                 rdata;
    logic signed [AccWidth-1:0]  acc;
    logic signed [FirWidth-1:0]  fir_next;
    logic [FirWidth-1:0]         fir_abs;
    logic                        unused_adr;

    assign unused_adr = ^{adr_i[31:5], adr_i[1:0]};

    cic_decimator #(
        .CicShift (CIC_SHIFT)
    ) u_cic (
        .clk       (clk),
        .rst       (rst),
        .en_i      (enable_q),
        .ce_pdm_i  (ce_pdm),
        .ce_pcm_i  (ce_pcm),
        .pdm_i     (pdm_data_i),
        .pcm_o     (cic_pcm),
        .pcm_vld_o (cic_vld)
    );

    // A request is accepted only when no ack is in flight, giving one ack per two cycles.
    assign bus_req  = valid_i && !ack_q;
    assign reg_addr = reg_addr_e'(adr_i[4:2]);

    always_comb begin
        acc = AccWidth'($signed(b0_q)) * AccWidth'(cic_pcm)
            + AccWidth'($signed(b1_q)) * AccWidth'(x1_q)
            + AccWidth'($signed(b2_q)) * AccWidth'(x2_q);
        fir_next = sat_fir(acc >>> FirFrac);
        if (fir_out_q == 16'sh8000) begin
            fir_abs = 16'h7FFF;
        end else if (fir_out_q[FirWidth-1]) begin
            fir_abs = FirWidth'(-fir_out_q);
        end else begin
            fir_abs = FirWidth'(fir_out_q);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_addr)
            RegCtrl:   rdata = {15'b0, enable_q};
            RegB0:     rdata = b0_q;
            RegB1:     rdata = b1_q;
            RegB2:     rdata = b2_q;
            RegThresh: rdata = thresh_q;
            RegFirOut: rdata = fir_out_q;
            RegPeak:   rdata = peak_q;
            RegCicOut: rdata = {{(16-PcmWidth){cic_pcm[PcmWidth-1]}}, cic_pcm};
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            enable_q <= CtrlEnableReset;
            b0_q     <= B0Reset;
            b1_q     <= B1Reset;
            b2_q     <= B2Reset;
            thresh_q <= ThreshReset;
        end else begin
            ack_q <= bus_req;
            dat_q <= (bus_req && !strb_i) ? rdata : 16'h0000;
            if (bus_req && strb_i) begin
                case (reg_addr)
                    RegCtrl:   enable_q <= dat_i[0];
                    RegB0:     b0_q     <= dat_i;
                    RegB1:     b1_q     <= dat_i;
                    RegB2:     b2_q     <= dat_i;
                    RegThresh: thresh_q <= dat_i;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q      <= '0;
            x2_q      <= '0;
            fir_out_q <= '0;
            fir_vld_q <= 1'b0;
            peak_q    <= '0;
            cmp_q     <= 1'b0;
        end else begin
            fir_vld_q <= 1'b0;
            if (enable_q && cic_vld) begin
                x1_q      <= cic_pcm;
                x2_q      <= x1_q;
                fir_out_q <= fir_next;
                fir_vld_q <= 1'b1;
            end
            if (mclear) begin
                peak_q <= '0;
                cmp_q  <= 1'b0;
            end else if (enable_q && fir_vld_q) begin
                if (fir_abs > peak_q) begin
                    peak_q <= fir_abs;
                end
                cmp_q <= (fir_abs > thresh_q);
            end
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign cmp   = cmp_q;

endmodule

// File: tb/tb_sonar_on_chip.sv
// Bench for sonar_on_chip: steady-state CIC/FIR/peak/threshold behaviour from a
// closed-form model, plus bus handshake, enable hold, mclear and reset checks.
module tb_sonar_on_chip;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] adr_i = '0;
    logic [15:0] dat_i = '0;
    logic        strb_i = 1'b0;
    logic        ack_o;
    logic [15:0] dat_o;
    logic        ce_pdm = 1'b0;
    logic        ce_pcm = 1'b0;
    logic        pdm_data_i = 1'b0;
    logic        mclear = 1'b0;
    logic        cmp;

    int checks = 0;
    int failures = 0;
    bit gen_en = 1'b0;
    int pdm_mode = 0;  // 0: constant 1, 1: constant 0, 2: alternating

    sonar_on_chip #(
        .CIC_SHIFT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .adr_i      (adr_i),
        .dat_i      (dat_i),
        .strb_i     (strb_i),
        .ack_o      (ack_o),
        .dat_o      (dat_o),
        .ce_pdm     (ce_pdm),
        .ce_pcm     (ce_pcm),
        .pdm_data_i (pdm_data_i),
        .mclear     (mclear),
        .cmp        (cmp)
    );

    initial forever #5 clk = ~clk;

    // ce_pdm every 4 clk, ce_pcm every 32 clk (R = 8).
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!gen_en) begin
                ce_pdm = 1'b0;
                ce_pcm = 1'b0;
                cnt    = 0;
            end else begin
                cnt    = cnt + 1;
                ce_pdm = (cnt % 4 == 0);
                ce_pcm = (cnt % 32 == 0);
                if (ce_pdm) begin
                    case (pdm_mode)
                        0:       pdm_data_i = 1'b1;
                        1:       pdm_data_i = 1'b0;
                        default: pdm_data_i = ~pdm_data_i;
                    endcase
                end
            end
        end
    end

    // Steady CIC output: gain R^3 = 512, shifted right by 4.
    function automatic int cic_model(input int mode);
        if (mode == 0) return 32;
        if (mode == 1) return -32;
        return 0;
    endfunction

    // All three taps see the same steady sample.
    function automatic logic [15:0] fir_model(input int x, input logic [15:0] b0,
                                              input logic [15:0] b1, input logic [15:0] b2);
        longint s;
        longint q;
        s = (longint'($signed(b0)) + longint'($signed(b1)) + longint'($signed(b2))) * x;
        q = s >>> 15;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    function automatic logic [15:0] abs_model(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s == -32768) return 16'h7FFF;
        if (s < 0) return 16'(-s);
        return 16'(s);
    endfunction

    task automatic bus_xfer(input logic [2:0] a, input logic wr, input logic [15:0] wd,
                            output logic [15:0] rd, output int acks);
        logic [31:0] adr;
        bit got;
        adr      = $urandom;
        adr[4:2] = a;
        @(negedge clk);
        valid_i = 1'b1;
        adr_i   = adr;
        strb_i  = wr;
        dat_i   = wd;
        acks    = 0;
        rd      = '0;
        got     = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack_o) begin
                got  = 1'b1;
                acks = acks + 1;
                rd   = dat_o;
            end
        end
        valid_i = 1'b0;
        strb_i  = 1'b0;
        @(posedge clk);
        #1;
        if (ack_o) acks = acks + 1;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
        logic [15:0] rd;
        int acks;
        bus_xfer(a, 1'b1, d, rd, acks);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
        mclear  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_mclear();
        @(negedge clk);
        mclear = 1'b1;
        @(negedge clk);
        mclear = 1'b0;
    endtask

    task automatic wait_pcm(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            if (ce_pcm) ok = 1'b1;
        end
    endtask

    task automatic check_defaults(input string tag);
        logic [15:0] exp_tab [8];
        logic [15:0] rd;
        int acks;
        exp_tab = '{16'h0001, 16'h7FFF, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            bus_xfer(3'(i), 1'b0, 16'h0, rd, acks);
            checks++;
            if (rd !== exp_tab[i] || acks !== 1) begin
                failures++;
                $display("FAIL %s_reg%0d got=%h acks=%0d want=%h acks=1", tag, i, rd, acks, exp_tab[i]);
            end
        end
    endtask

    task automatic test_reset();
        gen_en = 1'b0;
        do_reset();
        @(posedge clk);
        #1;
        checks++;
        if (ack_o !== 1'b0 || dat_o !== 16'h0 || cmp !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got ack=%b dat=%h cmp=%b want 0/0000/0", ack_o, dat_o, cmp);
        end
        check_defaults("reset");
    endtask

    task automatic test_pos_input();
        logic [15:0] rd;
        int acks;
        pdm_mode = 0;
        gen_en   = 1'b1;
        repeat (320) @(posedge clk);
        bus_xfer(3'd7, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== 16'(cic_model(0))) begin
            failures++;
            $display("FAIL pos_cic got=%h want=%h", rd, 16'(cic_model(0)));
        end
        bus_xfer(3'd5, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== fir_model(cic_model(0), 16'h7FFF, 16'h0, 16'h0)) begin
            failures++;
            $display("FAIL pos_fir got=%h want=%h", rd, fir_model(cic_model(0), 16'h7FFF, 16'h0, 16'h0));
        end
        reg_write(3'd4, 16'd10);
        repeat (64) @(posedge clk);
        #1;
        checks++;
        if (cmp !== 1'b1) begin
            failures++;
            $display("FAIL pos_cmp got=%b want=1", cmp);
        end
    endtask

    task automatic test_thresh_readback();
        logic [15:0] rd;
        int acks;
        reg_write(3'd4, 16'd40);
        repeat (64) @(posedge clk);
        #1;
        checks++;
        if (cmp !== 1'b0) begin
            failures++;
            $display("FAIL thresh40_cmp got=%b want=0", cmp);
        end
        bus_xfer(3'd4, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== 16'h0028 || acks !== 1) begin
            failures++;
            $display("FAIL thresh_readback got=%h acks=%0d want=0028 acks=1", rd, acks);
        end
    endtask

    task automatic test_mclear();
        logic [15:0] rd;
        int acks;
        bit ok;
        reg_write(3'd4, 16'd10);
        repeat (64) @(posedge clk);
        #1;
        checks++;
        if (cmp !== 1'b1) begin
            failures++;
            $display("FAIL mclear_pre_cmp got=%b want=1", cmp);
        end
        wait_pcm(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mclear_wait_pcm got=timeout want=ce_pcm");
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        mclear = 1'b1;
        @(posedge clk);
        #1;
        mclear = 1'b0;
        checks++;
        if (cmp !== 1'b0) begin
            failures++;
            $display("FAIL mclear_cmp got=%b want=0", cmp);
        end
        bus_xfer(3'd6, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL mclear_peak got=%h want=0000", rd);
        end
        wait_pcm(ok);
        @(posedge clk);
        #1;
        checks++;
        if (!ok || cmp !== 1'b0) begin
            failures++;
            $display("FAIL mclear_cmp_at_2clk got=%b ok=%b want=0", cmp, ok);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmp !== 1'b1) begin
            failures++;
            $display("FAIL mclear_cmp_at_3clk got=%b want=1", cmp);
        end
        bus_xfer(3'd6, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== abs_model(fir_model(32, 16'h7FFF, 16'h0, 16'h0))) begin
            failures++;
            $display("FAIL mclear_peak_again got=%h want=%h", rd,
                     abs_model(fir_model(32, 16'h7FFF, 16'h0, 16'h0)));
        end
    endtask

    task automatic test_neg_input();
        logic [15:0] rd;
        int acks;
        do_reset();
        pdm_mode = 1;
        reg_write(3'd1, 16'h4000);
        repeat (320) @(posedge clk);
        bus_xfer(3'd7, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== 16'(cic_model(1))) begin
            failures++;
            $display("FAIL neg_cic got=%h want=%h", rd, 16'(cic_model(1)));
        end
        bus_xfer(3'd5, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== fir_model(-32, 16'h4000, 16'h0, 16'h0)) begin
            failures++;
            $display("FAIL neg_fir got=%h want=%h", rd, fir_model(-32, 16'h4000, 16'h0, 16'h0));
        end
        pulse_mclear();
        repeat (64) @(posedge clk);
        bus_xfer(3'd6, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== 16'h0010) begin
            failures++;
            $display("FAIL neg_peak got=%h want=0010", rd);
        end
    endtask

    task automatic test_alternating();
        logic [15:0] rd;
        int acks;
        do_reset();
        pdm_mode = 2;
        reg_write(3'd4, 16'h0000);
        repeat (320) @(posedge clk);
        bus_xfer(3'd7, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL alt_cic got=%h want=0000", rd);
        end
        bus_xfer(3'd5, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL alt_fir got=%h want=0000", rd);
        end
        checks++;
        if (cmp !== 1'b0) begin
            failures++;
            $display("FAIL alt_cmp got=%b want=0", cmp);
        end
    endtask

    task automatic test_enable();
        logic [15:0] rd;
        int acks;
        pdm_mode = 0;
        repeat (320) @(posedge clk);
        reg_write(3'd0, 16'h0000);
        pdm_mode = 1;
        repeat (200) @(posedge clk);
        #1;
        checks++;
        if (cmp !== 1'b1) begin
            failures++;
            $display("FAIL en_cmp_hold got=%b want=1", cmp);
        end
        bus_xfer(3'd5, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== fir_model(32, 16'h7FFF, 16'h0, 16'h0)) begin
            failures++;
            $display("FAIL en_fir_hold got=%h want=%h", rd, fir_model(32, 16'h7FFF, 16'h0, 16'h0));
        end
        bus_xfer(3'd7, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== 16'h0020) begin
            failures++;
            $display("FAIL en_cic_hold got=%h want=0020", rd);
        end
        bus_xfer(3'd0, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== 16'h0000 || acks !== 1) begin
            failures++;
            $display("FAIL en_ctrl_read got=%h acks=%0d want=0000 acks=1", rd, acks);
        end
        reg_write(3'd0, 16'h0001);
        repeat (320) @(posedge clk);
        bus_xfer(3'd5, 1'b0, 16'h0, rd, acks);
        checks++;
        if (rd !== fir_model(-32, 16'h7FFF, 16'h0, 16'h0)) begin
            failures++;
            $display("FAIL en_fir_resume got=%h want=%h", rd, fir_model(-32, 16'h7FFF, 16'h0, 16'h0));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] adr;
        reg_write(3'd4, 16'h0123);
        adr      = $urandom;
        adr[4:2] = 3'd4;
        @(negedge clk);
        valid_i = 1'b1;
        adr_i   = adr;
        strb_i  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic exp_ack;
            logic [15:0] exp_dat;
            exp_ack = (i % 2 == 0);
            exp_dat = exp_ack ? 16'h0123 : 16'h0000;
            @(posedge clk);
            #1;
            checks++;
            if (ack_o !== exp_ack || dat_o !== exp_dat) begin
                failures++;
                $display("FAIL b2b_cycle%0d got ack=%b dat=%h want ack=%b dat=%h",
                         i, ack_o, dat_o, exp_ack, exp_dat);
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] rd;
        logic [15:0] b0, b1, b2, th, exp_fir;
        logic exp_cmp;
        int acks;
        int mode;
        for (int it = 0; it < 6; it++) begin
            mode = $urandom_range(0, 2);
            b0 = 16'($urandom);
            b1 = 16'($urandom);
            b2 = 16'($urandom);
            th = 16'($urandom_range(0, 120));
            pdm_mode = mode;
            reg_write(3'd1, b0);
            reg_write(3'd2, b1);
            reg_write(3'd3, b2);
            reg_write(3'd4, th);
            repeat (320) @(posedge clk);
            exp_fir = fir_model(cic_model(mode), b0, b1, b2);
            exp_cmp = (abs_model(exp_fir) > th);
            bus_xfer(3'd5, 1'b0, 16'h0, rd, acks);
            checks++;
            if (rd !== exp_fir) begin
                failures++;
                $display("FAIL rand%0d_fir got=%h want=%h", it, rd, exp_fir);
            end
            checks++;
            if (cmp !== exp_cmp) begin
                failures++;
                $display("FAIL rand%0d_cmp got=%b want=%b", it, cmp, exp_cmp);
            end
            pulse_mclear();
            repeat (64) @(posedge clk);
            bus_xfer(3'd6, 1'b0, 16'h0, rd, acks);
            checks++;
            if (rd !== abs_model(exp_fir)) begin
                failures++;
                $display("FAIL rand%0d_peak got=%h want=%h", it, rd, abs_model(exp_fir));
            end
            bus_xfer(3'd2, 1'b0, 16'h0, rd, acks);
            checks++;
            if (rd !== b1) begin
                failures++;
                $display("FAIL rand%0d_b1_readback got=%h want=%h", it, rd, b1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] adr;
        pdm_mode = 0;
        reg_write(3'd1, 16'h7FFF);
        reg_write(3'd2, 16'h0000);
        reg_write(3'd3, 16'h0000);
        reg_write(3'd4, 16'd10);
        repeat (320) @(posedge clk);
        #1;
        checks++;
        if (cmp !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre_cmp got=%b want=1", cmp);
        end
        adr      = $urandom;
        adr[4:2] = 3'd5;
        @(negedge clk);
        valid_i = 1'b1;
        adr_i   = adr;
        strb_i  = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ack_o !== 1'b0 || dat_o !== 16'h0 || cmp !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got ack=%b dat=%h cmp=%b want 0/0000/0", ack_o, dat_o, cmp);
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst     = 1'b0;
        gen_en  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ack_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_ack got=%b want=0", ack_o);
        end
        check_defaults("rstmid");
    endtask

    initial begin
        test_reset();
        test_pos_input();
        test_thresh_readback();
        test_mclear();
        test_neg_input();
        test_alternating();
        test_enable();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
